alu_control_pipe: RTL and testbench

- Registered, parametrised successor to the combinational ALU control decoder.
- Decodes alu_op plus instruction funct into an ALU control code, behind a valid/ready handshake.
- Multiply and divide functs are sequenced as multi-cycle operations; the block reports busy and stalls upstream while they run.
- Sits between the main control unit and the ALU / mult-div datapath in the MIPS core.

---
 rtl/alu_control_pipe.sv | 162 ++++++++++++++++
 tb/tb_alu_control_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake and multi-cycle mult/div sequencing.
// Optional op/illegal statistics counters when ALU_CTRL_STATS_EN is defined.
module alu_control_pipe #(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        instruction_5_0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_out,
    output logic              muldiv_busy,
    output logic              illegal_funct
`ifdef ALU_CTRL_STATS_EN
    ,
    output logic [15:0]       op_count,
    output logic [7:0]        illegal_count
`endif
);

    localparam int MAXL  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_out_q, alu_out_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        code;
    logic              ill;
    logic              is_mult;
    logic              is_div;
    logic              is_long;
    logic [CNT_W-1:0]  cnt_load;
    logic              accept;

    always_comb begin
        code    = 4'b0010;
        ill     = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        unique case (1'b1)
            (alu_op == 2'b00): code = 4'b0010;
            (alu_op == 2'b01): code = 4'b0110;
            (alu_op == 2'b11): code = 4'b0111;
            (alu_op == 2'b10): begin
                unique case (instruction_5_0)
                    6'b100000: code = 4'b0010;
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b100110: code = 4'b0011;
                    6'b100111: code = 4'b1100;
                    6'b101010: code = 4'b0111;
                    6'b101111: code = 4'b1101;
                    6'b000000: code = 4'b1000;
                    6'b000010: code = 4'b1001;
                    6'b011000: begin
                        code    = 4'b1010;
                        is_mult = 1'b1;
                    end
                    6'b011010: begin
                        code   = 4'b1011;
                        is_div = 1'b1;
                    end
                    default: begin
                        code = 4'b0010;
                        ill  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // A latency of 1 is indistinguishable from a single-cycle op, so it never enters BUSY.
    assign is_long  = (is_mult && (MULT_CYCLES > 1)) || (is_div && (DIV_CYCLES > 1));
    assign cnt_load = is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign alu_out     = alu_out_q;
    assign illegal_funct = illegal_q;
    assign muldiv_busy = (state_q == BUSY);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        alu_out_d   = alu_out_q;
        illegal_d   = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_out_d = CTRL_W'(code);
                    illegal_d = ill;
                    if (is_long) begin
                        state_d     = BUSY;
                        cnt_d       = cnt_load;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            illegal_q   <= illegal_d;
        end
    end

`ifdef ALU_CTRL_STATS_EN
    logic [15:0] op_cnt_q;
    logic [7:0]  ill_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_cnt_q  <= '0;
            ill_cnt_q <= '0;
        end else if (accept) begin
            if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
            if (ill && ill_cnt_q != 8'hFF) ill_cnt_q <= ill_cnt_q + 8'd1;
        end
    end

    assign op_count      = op_cnt_q;
    assign illegal_count = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe: random and directed ops against a cycle-timed reference model.
// Define ALU_CTRL_STATS_EN for both files to also check the statistics counters.
module tb_alu_control_pipe;

    localparam int MULT_L = 4;
    localparam int DIV_L  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] instruction_5_0;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_out;
    logic       muldiv_busy;
    logic       illegal_funct;
`ifdef ALU_CTRL_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  illegal_count;
`endif

    alu_control_pipe #(
        .CTRL_W(4),
        .MULT_CYCLES(MULT_L),
        .DIV_CYCLES(DIV_L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .instruction_5_0(instruction_5_0),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_out(alu_out),
        .muldiv_busy(muldiv_busy),
        .illegal_funct(illegal_funct)
`ifdef ALU_CTRL_STATS_EN
        ,
        .op_count(op_count),
        .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic       ill;
        int         acyc;
        int         vcyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    bit   mon_en = 0;
    bit   exp_rdy = 1;
    int   n_ops = 0;
    int   n_ill = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: table of the MIPS control codes and per-op latency in cycles.
    task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                              output logic [3:0] code, output logic ill, output int lat);
        ill = 0;
        lat = 1;
        if (op == 2'b00) code = 4'h2;
        else if (op == 2'b01) code = 4'h6;
        else if (op == 2'b11) code = 4'h7;
        else begin
            case (f)
                6'h20: code = 4'h2;
                6'h22: code = 4'h6;
                6'h24: code = 4'h0;
                6'h25: code = 4'h1;
                6'h26: code = 4'h3;
                6'h27: code = 4'hC;
                6'h2A: code = 4'h7;
                6'h2F: code = 4'hD;
                6'h00: code = 4'h8;
                6'h02: code = 4'h9;
                6'h18: begin code = 4'hA; lat = MULT_L; end
                6'h1A: begin code = 4'hB; lat = DIV_L; end
                default: begin code = 4'h2; ill = 1; end
            endcase
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [1:0] op, input logic [5:0] f, input bit ordy);
        int c;
        bit pres;
        bit inflight;
        logic [3:0] code;
        logic ill;
        int lat;
        @(posedge clk);
        #1;
        in_valid = v;
        alu_op = op;
        instruction_5_0 = f;
        out_ready = ordy;
        c = cyc;
        pres = (q.size() > 0) && (q[0].vcyc <= c);
        inflight = (q.size() > 0) && (q[$].vcyc > c);
        exp_rdy = !inflight && !(pres && !ordy);
        if (v && exp_rdy) begin
            ref_decode(op, f, code, ill, lat);
            q.push_back('{code, ill, c, c + lat});
            if (n_ops < 65535) n_ops++;
            if (ill && n_ill < 255) n_ill++;
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard head every cycle.
    bit eo;
    bit eb;
    always begin
        @(negedge clk);
        if (mon_en) begin
            eo = (q.size() > 0) && (q[0].vcyc <= cyc);
            eb = (q.size() > 0) && (q[$].acyc < cyc) && (q[$].vcyc > cyc);
            chk("out_valid", 32'(out_valid), 32'(eo));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("muldiv_busy", 32'(muldiv_busy), 32'(eb));
            if (eo && out_valid) begin
                chk("alu_out", 32'(alu_out), 32'(q[0].code));
                chk("illegal_funct", 32'(illegal_funct), 32'(q[0].ill));
            end
            if (eo && out_ready) void'(q.pop_front());
        end
    end

    logic [5:0] ftab[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2F, 6'h00, 6'h02, 6'h18, 6'h1A};
    logic [5:0] b2b[7] = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2F, 6'h26};

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        alu_op = 2'b00;
        instruction_5_0 = 6'h00;
        out_ready = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst alu_out", 32'(alu_out), 32'd0);
        chk("rst illegal", 32'(illegal_funct), 32'd0);
        chk("rst busy", 32'(muldiv_busy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        mon_en = 1;

        drive_cycle(1, 2'b00, 6'b010101, 1);
        foreach (b2b[i]) drive_cycle(1, 2'b10, b2b[i], 1);
        drive_cycle(0, 2'b00, 6'h00, 1);

        drive_cycle(1, 2'b10, 6'h18, 1);
        repeat (5) drive_cycle(0, 2'b00, 6'h00, 1);
        drive_cycle(1, 2'b10, 6'h1A, 1);
        repeat (9) drive_cycle(0, 2'b00, 6'h00, 1);

        drive_cycle(1, 2'b01, 6'h00, 0);
        repeat (5) drive_cycle(1, 2'($urandom), 6'($urandom), 0);
        drive_cycle(0, 2'b00, 6'h00, 1);

        drive_cycle(1, 2'b10, 6'h3F, 1);
        drive_cycle(0, 2'b00, 6'h00, 1);

        drive_cycle(1, 2'b10, 6'h1A, 1);
        drive_cycle(0, 2'b00, 6'h00, 1);
        drive_cycle(0, 2'b00, 6'h00, 1);
        @(posedge clk);
        #1;
        mon_en = 0;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst alu_out", 32'(alu_out), 32'd0);
        chk("midrst busy", 32'(muldiv_busy), 32'd0);
        chk("midrst illegal", 32'(illegal_funct), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        q.delete();
        n_ops = 0;
        n_ill = 0;
        exp_rdy = 1;
        @(negedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1;
        repeat (10) drive_cycle(0, 2'b00, 6'h00, 1);

        repeat (500) begin
            logic [5:0] f;
            f = ($urandom_range(0, 4) != 0) ? ftab[$urandom_range(0, 11)] : 6'($urandom);
            drive_cycle($urandom_range(0, 3) != 0, 2'($urandom), f, $urandom_range(0, 3) != 0);
        end

        repeat (20) drive_cycle(0, 2'b00, 6'h00, 1);
        chk("drain", 32'(q.size()), 32'd0);
`ifdef ALU_CTRL_STATS_EN
        chk("op_count", 32'(op_count), 32'(n_ops));
        chk("illegal_count", 32'(illegal_count), 32'(n_ill));
`endif
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
